// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; training comes from execute, one update per cycle.
module btb #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  output logic [31:0] btb_target_pc,
  input  logic        inv_all,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  // The two byte-offset bits of a PC never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign btb_pc_valid        = lk_hit;
  assign btb_pc_predictTaken = lk_hit && cnt_q[lk_idx][1];
  assign btb_target_pc       = lk_hit ? tgt_q[lk_idx] : 32'h0;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             ent_wr;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      tgt_d;
  logic [1:0]       cnt_d;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // upd_en is a single-cycle strobe with no back-pressure; inv_all drops it outright.
  always_comb begin
    ent_wr = 1'b0;
    tag_d  = tag_q[up_idx];
    tgt_d  = tgt_q[up_idx];
    cnt_d  = cnt_q[up_idx];
    if (upd_en && !inv_all) begin
      if (up_hit) begin
        ent_wr = 1'b1;
        if (upd_taken) begin
          cnt_d = (cnt_q[up_idx] == 2'b11) ? 2'b11 : cnt_q[up_idx] + 2'b01;
          tgt_d = upd_target;
        end else begin
          cnt_d = (cnt_q[up_idx] == 2'b00) ? 2'b00 : cnt_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        ent_wr = 1'b1;
        tag_d  = up_tag;
        tgt_d  = upd_target;
        cnt_d  = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= 2'b01;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (ent_wr) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_d;
    end
  end

  // Tags and targets need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && ent_wr) begin
      tag_q[up_idx] <= tag_d;
      tgt_q[up_idx] <= tgt_d;
    end
  end

endmodule
